// File: rtl/lib_vector_gen_if.sv
// lib_vector_gen_if: control and vector bus for lib_vector_gen.
// LIB_VECTOR_CHECK_EN adds the cell-output return path and error status.
interface lib_vector_gen_if #(parameter int VEC_W = 4);
  logic iStart, iEnb;
  logic oSel, oD, oA, oB;
  logic [VEC_W-1:0] oVecIdx;
  logic oValid, oBusy, oDone;
`ifdef LIB_VECTOR_CHECK_EN
  logic iNand, iNor, iNot, iMux, iQp, iQn;
  logic oErr;
  logic [7:0] oErrCnt;
  modport slave (input iStart, iEnb, iNand, iNor, iNot, iMux, iQp, iQn,
                 output oSel, oD, oA, oB, oVecIdx, oValid, oBusy, oDone, oErr, oErrCnt);
  modport master (output iStart, iEnb, iNand, iNor, iNot, iMux, iQp, iQn,
                  input oSel, oD, oA, oB, oVecIdx, oValid, oBusy, oDone, oErr, oErrCnt);
`else
  modport slave (input iStart, iEnb,
                 output oSel, oD, oA, oB, oVecIdx, oValid, oBusy, oDone);
  modport master (output iStart, iEnb,
                  input oSel, oD, oA, oB, oVecIdx, oValid, oBusy, oDone);
`endif
endinterface

// File: rtl/lib_vector_gen.sv
// lib_vector_gen: walks vectors {Sel,D,A,B}=idx, each held HOLD clocks.
// LIB_VECTOR_CHECK_EN adds a check of the returned cell outputs with a sticky error and a saturating count.
module lib_vector_gen #(
  parameter int VEC_W   = 4,
  parameter int HOLD    = 3,
  parameter int NUM_VEC = 16
) (
  input logic iClk,
  input logic iClr,
  lib_vector_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state;
  logic [7:0] r_hold;
  logic [VEC_W-1:0] r_idx;
  logic [3:0] r_vec;
  logic r_valid, r_busy, r_done;
  logic w_last_hold, w_last_idx, w_start;
  assign w_last_hold = r_hold == 8'(HOLD - 1);
  assign w_last_idx  = r_idx == VEC_W'(NUM_VEC - 1);
  assign w_start     = bus.iStart && r_state != RUN;
  // zero-extend or truncate the index onto the four vector bits
  function automatic logic [3:0] to_vec(input logic [VEC_W-1:0] i);
    logic [31:0] t;
    t = 32'(i);
    return t[3:0];
  endfunction
  always_ff @(posedge iClk or negedge iClr) begin
    if (!iClr) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_idx   <= '0;
      r_vec   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_start) begin
      r_state <= RUN;
      r_hold  <= '0;
      r_idx   <= '0;
      r_vec   <= '0;
      r_valid <= 1'b1;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_state == RUN && bus.iEnb) begin
      if (!w_last_hold) begin
        r_hold <= r_hold + 8'd1;
      end else if (!w_last_idx) begin
        r_hold <= '0;
        r_idx  <= r_idx + VEC_W'(1);
        r_vec  <= to_vec(r_idx + VEC_W'(1));
      end else begin
        r_state <= DONE;
        r_hold  <= '0;
        r_vec   <= '0;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end
  assign bus.oSel    = r_vec[3];
  assign bus.oD      = r_vec[2];
  assign bus.oA      = r_vec[1];
  assign bus.oB      = r_vec[0];
  assign bus.oVecIdx = r_idx;
  assign bus.oValid  = r_valid;
  assign bus.oBusy   = r_busy;
  assign bus.oDone   = r_done;
`ifdef LIB_VECTOR_CHECK_EN
  logic r_err;
  logic [7:0] r_err_cnt;
  logic w_chk, w_mis;
  // sampled on the last hold clock so the ffd has had time to capture D
  assign w_chk = r_state == RUN && bus.iEnb && w_last_hold;
  assign w_mis = bus.iNand != ~(r_vec[1] & r_vec[0]) || bus.iNor != ~(r_vec[1] | r_vec[0]) ||
                 bus.iNot != ~r_vec[1] || bus.iMux != (r_vec[3] ? r_vec[0] : r_vec[1]) ||
                 bus.iQp != r_vec[2] || bus.iQn != ~r_vec[2];
  always_ff @(posedge iClk or negedge iClr) begin
    if (!iClr) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_start) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_chk && w_mis) begin
      r_err     <= 1'b1;
      r_err_cnt <= r_err_cnt == 8'hff ? r_err_cnt : r_err_cnt + 8'd1;
    end
  end
  assign bus.oErr    = r_err;
  assign bus.oErrCnt = r_err_cnt;
`endif
endmodule
